// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The opcode and vector fields are decoded here so the pipeline agrees on one definition.
package fetch_pkg;

   localparam int         INSTR_W      = 32;
   localparam int         FETCH_ADDR_W = 32;
   localparam int         OPCODE_MSB   = 31;
   localparam int         OPCODE_LSB   = 26;
   localparam int         VECTOR_BIT   = 31;
   localparam logic [5:0] OP_HALT      = 6'h3F;

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      HALTED
   } fetch_state_t;

   typedef struct packed {
      logic [INSTR_W-1:0]      instr;
      logic [FETCH_ADDR_W-1:0] pc;
   } fetch_entry_t;

   function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
      return instr[OPCODE_MSB:OPCODE_LSB] == OP_HALT;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between the memory response path and decode.
// Flush wins over push; the head entry is read combinationally.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   input  fetch_entry_t           data_i,
   output fetch_entry_t           head_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   empty_o,
   output logic                   full_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   // NOTE: storage is deliberately not reset; only pointers and count are, and consumers gate the head with empty.
   always_ff @(posedge clk) begin
      if (do_push && !flush_i) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC sequencing, credit-limited memory requests, response buffering,
// redirect/halt handling and the valid/ready interface toward decode.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter int                ADDR_W     = FETCH_ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_PC   = '0,
   parameter int                FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_rvalid,
   input  logic [31:0]       imem_rdata,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              id_ready,
   output logic              if_valid,
   output logic [31:0]       if_instr,
   output logic [ADDR_W-1:0] if_pc,
   output logic              if_is_vector,
   output logic              halted
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d, resp_pc_q, resp_pc_d;
   logic [CNT_W-1:0]  outstanding_q, outstanding_d, discard_q, discard_d;

   fetch_entry_t      fifo_head, fifo_in;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_empty, fifo_full, fifo_push, fifo_pop, fifo_flush;
   logic              halt_pop, credit_ok;

   // Credits count both buffered words and words still in flight, so the buffer can never overflow.
   assign credit_ok  = ({1'b0, outstanding_q} + {1'b0, fifo_count}) < (CNT_W + 1)'(FIFO_DEPTH);

   assign if_valid   = !fifo_empty && !redirect;
   assign fifo_pop   = if_valid && id_ready;
   assign halt_pop   = fifo_pop && is_halt(fifo_head.instr);
   assign fifo_flush = redirect || halt_pop;
   assign fifo_push  = imem_rvalid && (discard_q == '0) && !fifo_flush;

   assign imem_req   = (state_q == RUN) && !redirect && !halt_pop && credit_ok;
   assign imem_addr  = pc_q;
   assign halted     = (state_q == HALTED);

   assign fifo_in.instr = imem_rdata;
   assign fifo_in.pc    = resp_pc_q;

   assign if_instr     = fifo_empty ? '0 : fifo_head.instr;
   assign if_pc        = fifo_empty ? '0 : fifo_head.pc;
   assign if_is_vector = !fifo_empty && fifo_head.instr[VECTOR_BIT];

   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .flush_i (fifo_flush),
      .data_i  (fifo_in),
      .head_o  (fifo_head),
      .count_o (fifo_count),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

   // NOTE: every variable gets its default first so no path through the block can infer a latch.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      resp_pc_d     = resp_pc_q;
      discard_d     = discard_q;
      outstanding_d = outstanding_q + CNT_W'(imem_req) - CNT_W'(imem_rvalid);

      if (imem_req)                            pc_d      = pc_q + ADDR_W'(4);
      if (fifo_push)                           resp_pc_d = resp_pc_q + ADDR_W'(4);
      if (imem_rvalid && (discard_q != '0))    discard_d = discard_q - CNT_W'(1);

      unique case (state_q)
         BOOT:    state_d = RUN;
         RUN:     if (halt_pop) state_d = HALTED;
         HALTED:  state_d = HALTED;
         default: state_d = BOOT;
      endcase

      // Everything in flight is stale after a flush; the word landing now is dropped directly.
      if (fifo_flush) discard_d = outstanding_q - CNT_W'(imem_rvalid);

      if (redirect) begin
         state_d   = RUN;
         pc_d      = redirect_pc;
         resp_pc_d = redirect_pc;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= BOOT;
         pc_q          <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         discard_q     <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
      end
   end

   assert property (@(posedge clk) disable iff (rst) !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage directly upstream of the decode stage.
- Holds the PC and issues in-order requests to instruction memory with latency of 1 or more cycles.
- Buffers returned words in a small FIFO and presents {instr, pc} to decode with a valid/ready handshake.
- Supports branch redirect with flush, discard of in-flight responses, and a HALT opcode that stops fetching.

Parameters:
- ADDR_W, 32, width of PC and instruction-memory address (byte address).
- RESET_PC, 0, first fetch address after reset.
- FIFO_DEPTH, 4, instruction buffer entries; power of two, ≥2; also the maximum number of outstanding requests.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request this cycle.
- imem_addr  out  ADDR_W  fetch address; valid when imem_req=1.
- imem_rvalid  in  1  response strobe; responses return in request order.
- imem_rdata  in  32  instruction word.
- redirect  in  1  branch/jump taken (from execute).
- redirect_pc  in  ADDR_W  new fetch target.
- id_ready  in  1  decode accepts the head instruction this cycle.
- if_valid  out  1  head instruction valid.
- if_instr  out  32  head instruction word.
- if_pc  out  ADDR_W  PC of head instruction.
- if_is_vector  out  1  if_instr[31]; vector ops have opcode MSB = 1.
- halted  out  1  fetch is in the HALTED state.

Behaviour:
- Reset (async, active-high): state=BOOT, pc=RESET_PC, resp_pc=RESET_PC, outstanding=0, discard=0, FIFO empty. Outputs: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, if_is_vector=0, halted=0. Instruction memory shares rst, so no responses are pending after reset.
- FSM states: BOOT, RUN, HALTED.
  - BOOT goes to RUN unconditionally one cycle after reset release; no request is issued in BOOT.
  - RUN goes to HALTED when a popped instruction has opcode (bits [31:26]) equal to OP_HALT.
  - HALTED goes to RUN on redirect. halted=1 only in HALTED.
- Issue rule: imem_req=1 iff state=RUN, !redirect, !halt_pop, and outstanding + fifo_count < FIFO_DEPTH. On issue, imem_addr=pc and pc advances by 4 (wraps modulo 2^ADDR_W). Credits guarantee the FIFO never overflows; an rvalid arriving while the FIFO is full is a protocol error (assertion).
- outstanding: incremented on each request, decremented on each rvalid (including discarded ones); both in the same cycle leaves it unchanged.
- Response path: rvalid with discard>0 drops the word and decrements discard. Otherwise it pushes {imem_rdata, resp_pc} and resp_pc advances by 4.
- Latency: request in cycle N, rvalid in cycle N+L, if_valid=1 in cycle N+L+1. There is no bypass from memory to output.
- Output: if_valid = !fifo_empty && !redirect. Pop when if_valid && id_ready. if_instr, if_pc and if_is_vector come from the FIFO head and are held stable while if_valid && !id_ready.
- Redirect (any state), applied in one cycle:
  - FIFO flushed, no pop, no request.
  - pc <= redirect_pc, resp_pc <= redirect_pc.
  - discard <= outstanding - (rvalid ? 1 : 0); the response arriving this cycle is dropped.
  - state <= RUN.
  - The first request to redirect_pc goes out the next cycle if credits allow.
- Halt pop (pop of an OP_HALT instruction):
  - The HALT itself is delivered to decode.
  - Remaining FIFO entries are flushed the same cycle.
  - In-flight responses are discarded using the same discard rule as redirect.
  - No further requests are issued.
- Simultaneous redirect and halt pop: redirect wins; the pop is suppressed.
- Simultaneous push and pop: both occur and fifo_count is unchanged.

Decomposition:
- Package fetch_pkg holds:
  - INSTR_W=32, OPCODE_MSB=31, OPCODE_LSB=26, VECTOR_BIT=31, OP_HALT=6'h3F.
  - typedef fetch_state_t {BOOT, RUN, HALTED}.
  - typedef fetch_entry_t {logic [31:0] instr; logic [ADDR_W-1:0] pc}.
- One sub-module, fetch_fifo: synchronous FIFO of fetch_entry_t with push, pop, flush, count, empty and full.
  - Flush has priority over push.
  - Async active-high reset on rst.

Test Plan:
- Reset then free run, memory L=1, id_ready=1: imem_addr 0,4,8,… one per cycle from the cycle after BOOT; if_pc 0 appears 2 cycles after the first request, then 4, 8 in consecutive cycles.
- Backpressure, id_ready=0 for 10 cycles with L=1: exactly 4 requests issue, then imem_req=0; if_instr/if_pc stay at pc=0; after id_ready=1, delivery is in order 0,4,8,12,16 with no loss or duplication.
- Redirect to 0x100 with 3 responses outstanding (L=3): the 3 late rvalids are dropped; the next delivered if_pc=0x100; if_valid=0 in the redirect cycle.
- HALT: word at pc 0x8 = 32'hFC000000 with 0xC and 0x10 already buffered: HALT delivered, halted=1 next cycle, 0xC and 0x10 never delivered, imem_req stays 0; redirect to 0x40 then fetches 0x40 and halted=0.
- Vector flag: instr 32'h84000000 gives if_is_vector=1; 32'h04000000 gives if_is_vector=0.
- Reset asserted mid-stream with full FIFO: all outputs reach reset values immediately (asynchronously); after release, fetch restarts at RESET_PC.
